priority_requester: RTL and testbench

Generates the 2-bit one-hot `priority` request that the traffic-light controller consumes, from raw east/west vehicle sensors. It synchronizes and debounces each sensor, arbitrates simultaneous demand, and holds the request until the controller's `light_state` shows the requested direction green or a hold timeout expires. A cooldown then follows. It sits in front of `top` in the intersection design and closes the loop on `light_state`.

---
 rtl/priority_requester_pkg.sv | 9 +
 rtl/priority_requester_if.sv | 19 +
 rtl/priority_requester_sensor_debounce.sv | 22 ++
 rtl/priority_requester.sv | 77 +++++++
 tb/tb_priority_requester.sv | 229 ++++++++++++++++++++++
 5 files changed

// File: rtl/priority_requester_pkg.sv
// priority_requester_pkg: light_state codes and priority encodings shared with the controller.
package priority_requester_pkg;
   typedef logic [1:0] prio_t;
   localparam logic [3:0] LS_EAST_GREEN = 4'd1;
   localparam logic [3:0] LS_WEST_GREEN = 4'd4;
   localparam prio_t PRIO_NONE = 2'b00;
   localparam prio_t PRIO_EAST = 2'b01;
   localparam prio_t PRIO_WEST = 2'b10;
endpackage

// File: rtl/priority_requester_if.sv
// priority_requester_if: sensor inputs, controller feedback and request outputs of the requester.
interface priority_requester_if;
   import priority_requester_pkg::*;
   logic sense_east;
   logic sense_west;
   logic [3:0] light_state;
   prio_t prio;
   logic served_east;
   logic served_west;
   logic timeout;
   modport master (
      input sense_east, sense_west, light_state,
      output prio, served_east, served_west, timeout
   );
   modport slave (
      output sense_east, sense_west, light_state,
      input prio, served_east, served_west, timeout
   );
endinterface

// File: rtl/priority_requester_sensor_debounce.sv
// sensor_debounce: 2-flop synchronizer plus a saturating run-length counter on the synced level.
module sensor_debounce #(
   parameter int DEBOUNCE_CYCLES = 4
) (
   input logic clk,
   input logic rst_n,
   input logic sense,
   output logic active
);
   localparam int W = $clog2(DEBOUNCE_CYCLES + 1);
   logic [1:0] sync;
   logic [W-1:0] cnt;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         sync <= '0;
         cnt <= '0;
      end else begin
         sync <= {sync[0], sense};
         cnt <= !sync[1] ? '0 : active ? cnt : cnt + W'(1);
      end
   assign active = cnt == W'(DEBOUNCE_CYCLES);
endmodule

// File: rtl/priority_requester.sv
// priority_requester: arbitrates debounced east/west demand into a one-hot request held until
// the controller shows that direction green or the hold timeout expires, then cools down.
module priority_requester
   import priority_requester_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int HOLD_TIMEOUT = 60,
   parameter int COOLDOWN = 20
) (
   input logic clk,
   input logic rst_n,
   priority_requester_if.master bus
);
   typedef enum logic [1:0] {IDLE, REQ_EAST, REQ_WEST, COOL} state_t;
   localparam int HW = $clog2(HOLD_TIMEOUT + 1);
   localparam int CW = $clog2(COOLDOWN + 1);
   state_t state, state_next;
   logic [HW-1:0] hold;
   logic [CW-1:0] cool;
   logic [3:0] ls_q;
   logic active_east, active_west, last_west;
   logic hit, expired, done;
   prio_t prio_d;
   logic served_east_d, served_west_d, timeout_d;

   sensor_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_debounce_east (
      .clk(clk), .rst_n(rst_n), .sense(bus.sense_east), .active(active_east)
   );
   sensor_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_debounce_west (
      .clk(clk), .rst_n(rst_n), .sense(bus.sense_west), .active(active_west)
   );

   assign hit = (state == REQ_EAST && ls_q == LS_EAST_GREEN) || (state == REQ_WEST && ls_q == LS_WEST_GREEN);
   assign expired = (state == REQ_EAST || state == REQ_WEST) && hold == HW'(HOLD_TIMEOUT - 1);
   assign done = state == COOL && cool == CW'(COOLDOWN - 1);

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state <= IDLE;
         hold <= '0;
         cool <= '0;
         ls_q <= '0;
         last_west <= 1'b1;
         bus.prio <= PRIO_NONE;
         bus.served_east <= 1'b0;
         bus.served_west <= 1'b0;
         bus.timeout <= 1'b0;
      end else begin
         state <= state_next;
         ls_q <= bus.light_state;
         hold <= (state == state_next && state != IDLE && state != COOL) ? hold + HW'(1) : '0;
         cool <= (state == COOL && state_next == COOL) ? cool + CW'(1) : '0;
         if (hit || expired) last_west <= state == REQ_WEST;
         bus.prio <= prio_d;
         bus.served_east <= served_east_d;
         bus.served_west <= served_west_d;
         bus.timeout <= timeout_d;
      end

   // Ties go to the side that was not served last, so neither side can starve.
   always_comb begin
      state_next = state;
      if (state == IDLE) begin
         if (active_east && (!active_west || last_west)) state_next = REQ_EAST;
         else if (active_west) state_next = REQ_WEST;
      end else if (state == COOL) begin
         if (done) state_next = IDLE;
      end else if (hit || expired) state_next = COOL;
   end

   always_comb begin
      prio_d = state_next == REQ_EAST ? PRIO_EAST : state_next == REQ_WEST ? PRIO_WEST : PRIO_NONE;
      served_east_d = hit && state == REQ_EAST;
      served_west_d = hit && state == REQ_WEST;
      timeout_d = expired && !hit;
   end
endmodule

// File: tb/tb_priority_requester.sv
// tb_priority_requester: directed scenarios plus a randomized run against a cycle-level model.
module tb_priority_requester;
   import priority_requester_pkg::*;
   localparam int D = 4;
   localparam int HT = 60;
   localparam int CD = 20;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int cmp = 0;
   int fail = 0;

   priority_requester_if bus();

   priority_requester #(.DEBOUNCE_CYCLES(D), .HOLD_TIMEOUT(HT), .COOLDOWN(CD)) dut (
      .clk(clk), .rst_n(rst_n), .bus(bus)
   );

   always #5 clk = ~clk;

   // Reference model: direction held (0 none, 1 east, 2 west), its age, cooldown left,
   // a window of raw sensor samples per edge, and the light_state seen at the previous edge.
   int m_dir, m_age, m_cool, m_last;
   logic [3:0] m_ls;
   bit hist_e[$], hist_w[$];
   bit m_se, m_sw, m_to;

   function automatic bit demand(input bit h[$]);
      for (int i = 2; i <= D + 1; i++) if (!h[i]) return 1'b0;
      return 1'b1;
   endfunction

   function automatic prio_t m_prio();
      return m_dir == 1 ? PRIO_EAST : m_dir == 2 ? PRIO_WEST : PRIO_NONE;
   endfunction

   task automatic model_reset();
      m_dir = 0; m_age = 0; m_cool = 0; m_last = 2; m_ls = '0;
      m_se = 0; m_sw = 0; m_to = 0;
      hist_e.delete(); hist_w.delete();
      for (int i = 0; i < D + 2; i++) begin
         hist_e.push_back(1'b0);
         hist_w.push_back(1'b0);
      end
   endtask

   task automatic model_step();
      bit ae, aw;
      ae = demand(hist_e);
      aw = demand(hist_w);
      m_se = 0; m_sw = 0; m_to = 0;
      if (m_dir != 0) begin
         if (m_ls == (m_dir == 1 ? LS_EAST_GREEN : LS_WEST_GREEN)) begin
            m_se = m_dir == 1; m_sw = m_dir == 2;
            m_last = m_dir; m_dir = 0; m_cool = CD;
         end else if (m_age == HT - 1) begin
            m_to = 1; m_last = m_dir; m_dir = 0; m_cool = CD;
         end else m_age++;
      end else if (m_cool > 0) m_cool--;
      else if (ae || aw) begin
         m_dir = (ae && aw) ? (m_last == 1 ? 2 : 1) : (ae ? 1 : 2);
         m_age = 0;
      end
      m_ls = bus.light_state;
      hist_e.push_front(bus.sense_east); void'(hist_e.pop_back());
      hist_w.push_front(bus.sense_west); void'(hist_w.pop_back());
   endtask

   initial model_reset();
   always @(posedge clk) if (!rst_n) model_reset(); else model_step();

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      bus.sense_east = 1'b0;
      bus.sense_west = 1'b0;
      bus.light_state = '0;
      repeat (2) tick();
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      do_reset();
      cmp++; if (bus.prio !== PRIO_NONE) begin fail++; $display("FAIL reset_prio: got %b want 00", bus.prio); end
      cmp++; if (bus.served_east !== 1'b0) begin fail++; $display("FAIL reset_served_east: got %b want 0", bus.served_east); end
      cmp++; if (bus.served_west !== 1'b0) begin fail++; $display("FAIL reset_served_west: got %b want 0", bus.served_west); end
      cmp++; if (bus.timeout !== 1'b0) begin fail++; $display("FAIL reset_timeout: got %b want 0", bus.timeout); end
   endtask

   task automatic test_east_served();
      int n, pulses, zeros;
      bus.sense_east = 1'b1;
      n = 0;
      do begin tick(); n++; end while (bus.prio == PRIO_NONE && n < 100);
      cmp++; if (n !== D + 3 || bus.prio !== PRIO_EAST) begin fail++; $display("FAIL east_latency: got %0d cycles prio %b, want %0d cycles prio 01", n, bus.prio, D + 3); end
      repeat (10) tick();
      bus.light_state = LS_EAST_GREEN;
      tick();
      cmp++; if (bus.prio !== PRIO_EAST) begin fail++; $display("FAIL east_hold_before_service: got %b want 01", bus.prio); end
      tick();
      bus.light_state = '0;
      cmp++; if (bus.served_east !== 1'b1 || bus.prio !== PRIO_NONE) begin fail++; $display("FAIL east_served: got served %b prio %b, want 1 00", bus.served_east, bus.prio); end
      pulses = 1; zeros = 1;
      do begin tick(); pulses += bus.served_east; if (bus.prio == PRIO_NONE) zeros++; end while (bus.prio == PRIO_NONE && zeros < 100);
      cmp++; if (pulses !== 1) begin fail++; $display("FAIL east_single_pulse: got %0d pulses want 1", pulses); end
      cmp++; if (zeros !== CD + 1 || bus.prio !== PRIO_EAST) begin fail++; $display("FAIL east_gap: got %0d idle cycles prio %b, want %0d then 01", zeros, bus.prio, CD + 1); end
   endtask

   task automatic test_tie();
      int n;
      do_reset();
      bus.sense_east = 1'b1;
      bus.sense_west = 1'b1;
      n = 0;
      do begin tick(); n++; end while (bus.prio == PRIO_NONE && n < 100);
      cmp++; if (bus.prio !== PRIO_EAST) begin fail++; $display("FAIL tie_first: got %b want 01", bus.prio); end
      bus.light_state = LS_EAST_GREEN;
      repeat (2) tick();
      bus.light_state = '0;
      cmp++; if (bus.served_east !== 1'b1) begin fail++; $display("FAIL tie_served_east: got %b want 1", bus.served_east); end
      n = 0;
      do begin tick(); n++; end while (bus.prio == PRIO_NONE && n < 100);
      cmp++; if (bus.prio !== PRIO_WEST || n !== CD + 1) begin fail++; $display("FAIL tie_second: got %b after %0d cycles, want 10 after %0d", bus.prio, n, CD + 1); end
   endtask

   task automatic test_timeout();
      int n, high;
      do_reset();
      bus.sense_west = 1'b1;
      n = 0;
      do begin tick(); n++; end while (bus.prio == PRIO_NONE && n < 100);
      cmp++; if (bus.prio !== PRIO_WEST) begin fail++; $display("FAIL timeout_grant: got %b want 10", bus.prio); end
      bus.sense_east = 1'b1;
      high = 1;
      do begin tick(); if (bus.prio == PRIO_WEST) high++; end while (bus.prio == PRIO_WEST && high < 200);
      cmp++; if (high !== HT) begin fail++; $display("FAIL timeout_hold: got %0d cycles want %0d", high, HT); end
      cmp++; if (bus.timeout !== 1'b1 || bus.served_west !== 1'b0) begin fail++; $display("FAIL timeout_pulse: got timeout %b served %b, want 1 0", bus.timeout, bus.served_west); end
      tick();
      cmp++; if (bus.timeout !== 1'b0) begin fail++; $display("FAIL timeout_width: got %b want 0", bus.timeout); end
      n = 0;
      do begin tick(); n++; end while (bus.prio == PRIO_NONE && n < 100);
      cmp++; if (bus.prio !== PRIO_EAST) begin fail++; $display("FAIL timeout_next_east: got %b want 01", bus.prio); end
   endtask

   task automatic test_glitch();
      logic [6:0] pat = 7'b1110111;
      bit seen = 0;
      int n;
      do_reset();
      for (int i = 6; i >= 0; i--) begin
         bus.sense_east = pat[i];
         tick();
         if (bus.prio != PRIO_NONE) seen = 1;
      end
      bus.sense_east = 1'b0;
      repeat (10) begin tick(); if (bus.prio != PRIO_NONE) seen = 1; end
      cmp++; if (seen !== 1'b0) begin fail++; $display("FAIL glitch_quiet: got request want none"); end
      bus.sense_east = 1'b1;
      n = 0;
      do begin tick(); n++; end while (bus.prio == PRIO_NONE && n < 100);
      cmp++; if (n !== D + 3 || bus.prio !== PRIO_EAST) begin fail++; $display("FAIL glitch_hold: got %0d cycles prio %b, want %0d 01", n, bus.prio, D + 3); end
   endtask

   task automatic test_async_reset();
      int n;
      cmp++; if (bus.prio !== PRIO_EAST) begin fail++; $display("FAIL areset_pre: got %b want 01", bus.prio); end
      #2 rst_n = 1'b0;
      #1;
      cmp++; if (bus.prio !== PRIO_NONE) begin fail++; $display("FAIL areset_drop: got %b want 00", bus.prio); end
      tick();
      rst_n = 1'b1;
      n = 0;
      do begin tick(); n++; end while (bus.prio == PRIO_NONE && n < 100);
      cmp++; if (n !== D + 3 || bus.prio !== PRIO_EAST) begin fail++; $display("FAIL areset_resume: got %0d cycles prio %b, want %0d 01", n, bus.prio, D + 3); end
   endtask

   task automatic test_west_instant();
      int n;
      do_reset();
      bus.light_state = LS_WEST_GREEN;
      bus.sense_west = 1'b1;
      n = 0;
      do begin tick(); n++; end while (bus.prio == PRIO_NONE && n < 100);
      cmp++; if (bus.prio !== PRIO_WEST) begin fail++; $display("FAIL instant_grant: got %b want 10", bus.prio); end
      tick();
      cmp++; if (bus.prio !== PRIO_NONE || bus.served_west !== 1'b1) begin fail++; $display("FAIL instant_served: got prio %b served %b, want 00 1", bus.prio, bus.served_west); end
   endtask

   task automatic test_random();
      logic [3:0] codes [4] = '{4'd0, LS_EAST_GREEN, LS_WEST_GREEN, 4'd7};
      logic [4:0] got, want;
      do_reset();
      for (int i = 0; i < 2500; i++) begin
         if ($urandom_range(7) == 0) bus.sense_east = ~bus.sense_east;
         if ($urandom_range(7) == 0) bus.sense_west = ~bus.sense_west;
         if ($urandom_range(9) == 0) bus.light_state = codes[$urandom_range(3)];
         tick();
         got = {bus.prio, bus.served_east, bus.served_west, bus.timeout};
         want = {m_prio(), m_se, m_sw, m_to};
         cmp++; if (got !== want) begin fail++; $display("FAIL random_cycle_%0d: got prio/se/sw/to %b want %b", i, got, want); end
      end
   endtask

   initial begin
      bus.sense_east = 1'b0;
      bus.sense_west = 1'b0;
      bus.light_state = '0;
      test_reset();
      test_east_served();
      test_tie();
      test_timeout();
      test_glitch();
      test_async_reset();
      test_west_instant();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, %0d compared", cmp);
      $fatal(1);
   end
endmodule
